flag_sequencer: RTL and testbench

- Parametrised successor to the pride-flag index counter.
- Converts raw, asynchronous push-button inputs into a frame-synchronised flag index for the flag_index lookup.
- Adds synchronisers, debounce, priority command decode, optional auto-cycling with a programmable per-flag dwell time, and tear-free index updates at frame start.
- Sits between the board inputs and the flag colour lookup, clocked by the pixel clock alongside hvsync_generator.

---
 rtl/flag_sequencer_if.sv | 28 ++
 rtl/flag_sequencer.sv | 147 ++++++++++++++
 tb/tb_flag_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_sequencer_if.sv
// Bundle of button, auto-cycle and frame controls going into flag_sequencer,
// plus the index outputs it returns to the flag colour lookup.
interface flag_sequencer_if #(
  parameter int IDX_W   = 7,
  parameter int DWELL_W = 8
);
  logic               btn_clear;
  logic               btn_next;
  logic               btn_prev;
  logic               btn_load;
  logic [IDX_W-1:0]   load_value;
  logic               auto_en;
  logic [DWELL_W-1:0] dwell;
  logic               frame_start;
  logic [IDX_W-1:0]   flag_idx;
  logic [IDX_W-1:0]   pending_idx;
  logic               changed;

  modport master (
    output btn_clear, btn_next, btn_prev, btn_load, load_value, auto_en, dwell, frame_start,
    input  flag_idx, pending_idx, changed
  );

  modport slave (
    input  btn_clear, btn_next, btn_prev, btn_load, load_value, auto_en, dwell, frame_start,
    output flag_idx, pending_idx, changed
  );
endinterface

// File: rtl/flag_sequencer.sv
// Turns raw push buttons into a frame-synchronised flag index: synchronise, debounce,
// priority-decode commands, optionally auto-advance, and commit at frame start.
module flag_sequencer #(
  parameter int NUM_FLAGS     = 64,
  parameter int IDX_W         = 7,
  parameter int DEBOUNCE_W    = 16,
  parameter int DWELL_W       = 8,
  parameter int SYNC_TO_FRAME = 1
) (
  input logic             clk,
  input logic             reset,
  flag_sequencer_if.slave bus
);

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_FLAGS - 1);
  localparam logic [IDX_W-1:0]      ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [DEBOUNCE_W-1:0] DB_MAX   = {DEBOUNCE_W{1'b1}};
  localparam logic [DEBOUNCE_W-1:0] DB_ZERO  = {DEBOUNCE_W{1'b0}};
  localparam logic [DWELL_W-1:0]    DW_ZERO  = {DWELL_W{1'b0}};

  // Button bit order throughout: [0]=clear, [1]=next, [2]=prev, [3]=load.
  logic [3:0]                 raw_s;
  logic [3:0]                 sync1_q;
  logic [3:0]                 sync2_q;
  logic [3:0]                 level_q;
  logic [3:0]                 level_d;
  logic [3:0]                 press_s;
  logic [3:0][DEBOUNCE_W-1:0] db_cnt_q;
  logic [3:0][DEBOUNCE_W-1:0] db_cnt_d;
  logic [DWELL_W-1:0]         dwell_cnt_q;
  logic [DWELL_W-1:0]         dwell_cnt_d;
  logic [DWELL_W-1:0]         dwell_lim_s;
  logic                       auto_adv_s;
  logic [IDX_W-1:0]           pending_q;
  logic [IDX_W-1:0]           pending_d;
  logic [IDX_W-1:0]           flag_q;
  logic [IDX_W-1:0]           flag_d;
  logic                       changed_q;

  function automatic logic [IDX_W-1:0] step_up(input logic [IDX_W-1:0] v);
    return (v == LAST_IDX) ? ZERO_IDX : v + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] step_down(input logic [IDX_W-1:0] v);
    return (v == ZERO_IDX) ? LAST_IDX : v - IDX_W'(1);
  endfunction

  assign raw_s = {bus.btn_load, bus.btn_prev, bus.btn_next, bus.btn_clear};

  // Debounce: the level flips only on the cycle the counter is saturated and still disagreeing.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    press_s  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = DB_ZERO;
      end else if (db_cnt_q[i] == DB_MAX) begin
        level_d[i]  = sync2_q[i];
        db_cnt_d[i] = DB_ZERO;
        press_s[i]  = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DEBOUNCE_W'(1);
      end
    end
  end

  assign dwell_lim_s = (bus.dwell == DW_ZERO) ? DW_ZERO : bus.dwell - DWELL_W'(1);

  // Dwell counting; a manual command both resets the count and suppresses the auto-advance.
  always_comb begin
    dwell_cnt_d = dwell_cnt_q;
    auto_adv_s  = 1'b0;
    if (press_s != 4'b0000) begin
      dwell_cnt_d = DW_ZERO;
    end else if (!bus.auto_en) begin
      dwell_cnt_d = DW_ZERO;
    end else if (bus.frame_start) begin
      if (dwell_cnt_q == dwell_lim_s) begin
        dwell_cnt_d = DW_ZERO;
        auto_adv_s  = 1'b1;
      end else begin
        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
      end
    end else begin
      dwell_cnt_d = dwell_cnt_q;
    end
  end

  // Priority command decode: clear > next > prev > load > auto.
  always_comb begin
    pending_d = pending_q;
    if (press_s[0]) begin
      pending_d = ZERO_IDX;
    end else if (press_s[1]) begin
      pending_d = step_up(pending_q);
    end else if (press_s[2]) begin
      pending_d = step_down(pending_q);
    end else if (press_s[3]) begin
      pending_d = (bus.load_value > LAST_IDX) ? LAST_IDX : bus.load_value;
    end else if (auto_adv_s) begin
      pending_d = step_up(pending_q);
    end else begin
      pending_d = pending_q;
    end
  end

  // Commit point for the visible index.
  always_comb begin
    flag_d = flag_q;
    if (SYNC_TO_FRAME == 0) begin
      flag_d = pending_d;
    end else if (bus.frame_start) begin
      flag_d = pending_d;
    end else begin
      flag_d = flag_q;
    end
  end

  // All state, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 4'b0000;
      sync2_q     <= 4'b0000;
      level_q     <= 4'b0000;
      db_cnt_q    <= {4{DB_ZERO}};
      dwell_cnt_q <= DW_ZERO;
      pending_q   <= ZERO_IDX;
      flag_q      <= ZERO_IDX;
      changed_q   <= 1'b0;
    end else begin
      sync1_q     <= raw_s;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      db_cnt_q    <= db_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      pending_q   <= pending_d;
      flag_q      <= flag_d;
      changed_q   <= (flag_d != flag_q);
    end
  end

  assign bus.flag_idx    = flag_q;
  assign bus.pending_idx = pending_q;
  assign bus.changed     = changed_q;

endmodule

// File: tb/tb_flag_sequencer.sv
// Bench for flag_sequencer: directed scenarios plus randomized traffic against a cycle model,
// with frame-synchronised (a) and free-running (b) instances sharing the same inputs.
module tb_flag_sequencer;
  localparam int NF   = 5;
  localparam int DBW  = 2;
  localparam int DWW  = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  flag_sequencer_if #(.IDX_W(4), .DWELL_W(DWW)) ifa ();
  flag_sequencer_if #(.IDX_W(4), .DWELL_W(DWW)) ifb ();

  assign ifb.btn_clear   = ifa.btn_clear;
  assign ifb.btn_next    = ifa.btn_next;
  assign ifb.btn_prev    = ifa.btn_prev;
  assign ifb.btn_load    = ifa.btn_load;
  assign ifb.load_value  = ifa.load_value;
  assign ifb.auto_en     = ifa.auto_en;
  assign ifb.dwell       = ifa.dwell;
  assign ifb.frame_start = ifa.frame_start;

  flag_sequencer #(.NUM_FLAGS(NF), .IDX_W(4), .DEBOUNCE_W(DBW), .DWELL_W(DWW), .SYNC_TO_FRAME(1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  flag_sequencer #(.NUM_FLAGS(NF), .IDX_W(4), .DEBOUNCE_W(DBW), .DWELL_W(DWW), .SYNC_TO_FRAME(0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: raw delay line, debounced levels, disagreement run lengths.
  bit [3:0] m_d1, m_d2, m_lvl;
  int m_run [4];
  int m_pend, m_fa, m_fb, m_dwc;
  bit m_ca, m_cb;

  task automatic model_step();
    bit [3:0] raw;
    bit [3:0] prs;
    int lim, p, nfa;
    bit adv;
    raw = {ifa.btn_load, ifa.btn_prev, ifa.btn_next, ifa.btn_clear};
    if (reset) begin
      m_d1 = 4'b0; m_d2 = 4'b0; m_lvl = 4'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_pend = 0; m_fa = 0; m_fb = 0; m_dwc = 0; m_ca = 1'b0; m_cb = 1'b0;
      return;
    end
    prs = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_d2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == (1 << DBW)) begin
          m_lvl[i] = m_d2[i];
          m_run[i] = 0;
          prs[i] = m_d2[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = raw;
    lim = (int'(ifa.dwell) == 0) ? 1 : int'(ifa.dwell);
    adv = 1'b0;
    if (prs != 4'b0 || !ifa.auto_en) m_dwc = 0;
    else if (ifa.frame_start) begin
      if (m_dwc == lim - 1) begin adv = 1'b1; m_dwc = 0; end
      else m_dwc = (m_dwc + 1) % (1 << DWW);
    end
    p = m_pend;
    if (prs[0]) p = 0;
    else if (prs[1]) p = (m_pend + 1) % NF;
    else if (prs[2]) p = (m_pend + NF - 1) % NF;
    else if (prs[3]) p = (int'(ifa.load_value) < NF) ? int'(ifa.load_value) : NF - 1;
    else if (adv) p = (m_pend + 1) % NF;
    m_pend = p;
    nfa = ifa.frame_start ? p : m_fa;
    m_ca = (nfa != m_fa);
    m_fa = nfa;
    m_cb = (p != m_fb);
    m_fb = p;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic clear_inputs();
    ifa.btn_clear = 1'b0; ifa.btn_next = 1'b0; ifa.btn_prev = 1'b0; ifa.btn_load = 1'b0;
    ifa.load_value = 4'd0; ifa.auto_en = 1'b0; ifa.dwell = 4'd0; ifa.frame_start = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic frame_pulse();
    ifa.frame_start = 1'b1;
    cyc(1);
    ifa.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (ifa.flag_idx !== 4'd0 || ifa.pending_idx !== 4'd0 || ifa.changed !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: flag=%0d pend=%0d chg=%0b, want 0/0/0", ifa.flag_idx, ifa.pending_idx, ifa.changed);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ifa.load_value = 4'd4; ifa.btn_load = 1'b1; cyc(10); ifa.btn_load = 1'b0; cyc(8);
    frame_pulse();
    n_vec++;
    if (ifa.flag_idx !== 4'd4) begin n_bad++; $display("FAIL wrap_setup: flag=%0d want 4", ifa.flag_idx); end
    cyc(3);
    ifa.btn_next = 1'b1;
    cyc(5);
    n_vec++;
    if (ifa.pending_idx !== 4'd4) begin n_bad++; $display("FAIL wrap_early: pend=%0d want 4", ifa.pending_idx); end
    cyc(1);
    n_vec++;
    if (ifa.pending_idx !== 4'd0 || ifa.flag_idx !== 4'd4) begin
      n_bad++; $display("FAIL wrap_next: pend=%0d flag=%0d want 0/4", ifa.pending_idx, ifa.flag_idx);
    end
    cyc(4); ifa.btn_next = 1'b0; cyc(8);
    frame_pulse();
    n_vec++;
    if (ifa.flag_idx !== 4'd0 || ifa.changed !== 1'b1) begin
      n_bad++; $display("FAIL wrap_commit: flag=%0d chg=%0b want 0/1", ifa.flag_idx, ifa.changed);
    end
    cyc(1);
    n_vec++;
    if (ifa.changed !== 1'b0) begin n_bad++; $display("FAIL wrap_chg_once: chg=%0b want 0", ifa.changed); end
    ifa.btn_prev = 1'b1;
    cyc(6);
    n_vec++;
    if (ifa.pending_idx !== 4'd4) begin n_bad++; $display("FAIL wrap_prev: pend=%0d want 4", ifa.pending_idx); end
    cyc(4); ifa.btn_prev = 1'b0; cyc(8);
    frame_pulse();
    n_vec++;
    if (ifa.flag_idx !== 4'd4 || ifa.changed !== 1'b1) begin
      n_bad++; $display("FAIL wrap_prev_commit: flag=%0d chg=%0b want 4/1", ifa.flag_idx, ifa.changed);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ifa.btn_next = (k % 2 == 0);
      cyc(2);
    end
    n_vec++;
    if (ifa.pending_idx !== 4'd0) begin n_bad++; $display("FAIL bounce_noise: pend=%0d want 0", ifa.pending_idx); end
    ifa.btn_next = 1'b1;
    cyc(5);
    n_vec++;
    if (ifa.pending_idx !== 4'd0) begin n_bad++; $display("FAIL bounce_early: pend=%0d want 0", ifa.pending_idx); end
    cyc(1);
    n_vec++;
    if (ifa.pending_idx !== 4'd1) begin n_bad++; $display("FAIL bounce_step: pend=%0d want 1", ifa.pending_idx); end
    cyc(10);
    n_vec++;
    if (ifa.pending_idx !== 4'd1) begin n_bad++; $display("FAIL bounce_once: pend=%0d want 1", ifa.pending_idx); end
    ifa.btn_next = 1'b0; cyc(8);
  endtask

  task automatic test_priority();
    do_reset();
    ifa.load_value = 4'd3; ifa.btn_load = 1'b1; cyc(8); ifa.btn_load = 1'b0; cyc(8);
    ifa.btn_clear = 1'b1; ifa.btn_next = 1'b1;
    cyc(6);
    n_vec++;
    if (ifa.pending_idx !== 4'd0) begin n_bad++; $display("FAIL prio_clear: pend=%0d want 0", ifa.pending_idx); end
    cyc(3);
    n_vec++;
    if (ifa.pending_idx !== 4'd0) begin n_bad++; $display("FAIL prio_single: pend=%0d want 0", ifa.pending_idx); end
    ifa.btn_clear = 1'b0; ifa.btn_next = 1'b0; cyc(8);
    ifa.load_value = 4'd9; ifa.btn_load = 1'b1; cyc(8); ifa.btn_load = 1'b0; cyc(8);
    n_vec++;
    if (ifa.pending_idx !== 4'd4) begin n_bad++; $display("FAIL load_clamp: pend=%0d want 4", ifa.pending_idx); end
    ifa.load_value = 4'd2; ifa.btn_load = 1'b1; cyc(8); ifa.btn_load = 1'b0; cyc(8);
    n_vec++;
    if (ifa.pending_idx !== 4'd2) begin n_bad++; $display("FAIL load_plain: pend=%0d want 2", ifa.pending_idx); end
  endtask

  task automatic test_auto();
    do_reset();
    ifa.auto_en = 1'b1; ifa.dwell = 4'd3;
    for (int k = 1; k <= 10; k++) begin
      frame_pulse();
      n_vec++;
      if (ifa.flag_idx !== 4'(k / 3)) begin
        n_bad++; $display("FAIL auto_dwell3: pulse %0d flag=%0d want %0d", k, ifa.flag_idx, k / 3);
      end
      cyc(3);
    end
    do_reset();
    ifa.auto_en = 1'b1; ifa.dwell = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      frame_pulse();
      n_vec++;
      if (ifa.flag_idx !== 4'(k % NF)) begin
        n_bad++; $display("FAIL auto_dwell0: pulse %0d flag=%0d want %0d", k, ifa.flag_idx, k % NF);
      end
      cyc(2);
    end
  endtask

  task automatic test_frame_sync();
    do_reset();
    ifa.btn_next = 1'b1;
    cyc(6);
    n_vec++;
    if (ifa.pending_idx !== 4'd1 || ifa.flag_idx !== 4'd0 || ifb.flag_idx !== 4'd1) begin
      n_bad++;
      $display("FAIL fsync_pulse: pend=%0d flag_a=%0d flag_b=%0d want 1/0/1", ifa.pending_idx, ifa.flag_idx, ifb.flag_idx);
    end
    ifa.btn_next = 1'b0;
    cyc(4);
    n_vec++;
    if (ifa.flag_idx !== 4'd0) begin n_bad++; $display("FAIL fsync_hold: flag=%0d want 0", ifa.flag_idx); end
    frame_pulse();
    n_vec++;
    if (ifa.flag_idx !== 4'd1) begin n_bad++; $display("FAIL fsync_commit: flag=%0d want 1", ifa.flag_idx); end
    cyc(4);
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifa.auto_en = 1'b1; ifa.dwell = 4'd3;
    frame_pulse(); cyc(2); frame_pulse(); cyc(2);
    ifa.btn_next = 1'b1;
    cyc(3);
    ifa.btn_next = 1'b0; reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    n_vec++;
    if (ifa.flag_idx !== 4'd0 || ifa.pending_idx !== 4'd0 || ifa.changed !== 1'b0) begin
      n_bad++; $display("FAIL midrst_zero: flag=%0d pend=%0d chg=%0b want 0", ifa.flag_idx, ifa.pending_idx, ifa.changed);
    end
    cyc(8);
    n_vec++;
    if (ifa.pending_idx !== 4'd0) begin n_bad++; $display("FAIL midrst_discard: pend=%0d want 0", ifa.pending_idx); end
    for (int k = 1; k <= 3; k++) begin
      frame_pulse();
      n_vec++;
      if (ifa.flag_idx !== 4'(k / 3)) begin
        n_bad++; $display("FAIL midrst_dwell: pulse %0d flag=%0d want %0d", k, ifa.flag_idx, k / 3);
      end
      cyc(2);
    end
    ifa.btn_prev = 1'b1;
    cyc(5);
    n_vec++;
    if (ifa.pending_idx !== 4'd1) begin n_bad++; $display("FAIL midrst_early: pend=%0d want 1", ifa.pending_idx); end
    cyc(1);
    n_vec++;
    if (ifa.pending_idx !== 4'd0) begin n_bad++; $display("FAIL midrst_press: pend=%0d want 0", ifa.pending_idx); end
    ifa.btn_prev = 1'b0; cyc(8);
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 11) == 0) ifa.btn_clear = ~ifa.btn_clear && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) ifa.btn_next  = ~ifa.btn_next;
      if ($urandom_range(0, 11) == 0) ifa.btn_prev  = ~ifa.btn_prev;
      if ($urandom_range(0, 11) == 0) ifa.btn_load  = ~ifa.btn_load;
      if ($urandom_range(0, 7) == 0)  ifa.load_value = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) ifa.auto_en = ~ifa.auto_en;
      if ($urandom_range(0, 149) == 0) ifa.dwell = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 59) == 0) ifa.dwell = 4'($urandom_range(0, 3));
      ifa.frame_start = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 599) == 0);
      cyc(1);
      n_vec++;
      if (ifa.pending_idx !== 4'(m_pend) || ifa.flag_idx !== 4'(m_fa) || ifa.changed !== m_ca) begin
        n_bad++;
        $display("FAIL rand_a cyc %0d: pend=%0d flag=%0d chg=%0b want %0d/%0d/%0b",
                 k, ifa.pending_idx, ifa.flag_idx, ifa.changed, m_pend, m_fa, m_ca);
      end
      n_vec++;
      if (ifb.pending_idx !== 4'(m_pend) || ifb.flag_idx !== 4'(m_fb) || ifb.changed !== m_cb) begin
        n_bad++;
        $display("FAIL rand_b cyc %0d: pend=%0d flag=%0d chg=%0b want %0d/%0d/%0b",
                 k, ifb.pending_idx, ifb.flag_idx, ifb.changed, m_pend, m_fb, m_cb);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_wrap();
    test_bounce();
    test_priority();
    test_auto();
    test_frame_sync();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
